// File: rtl/alu_writeback_ctrl_pkg.sv
// Shared definitions for the ALU writeback controller:
// condition codes, ALU op types, FSM states and the condition rule.
package alu_writeback_ctrl_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_REG_AW = 3;
    localparam int DEF_PC_REG = 7;

    localparam logic [1:0] COND_ALWAYS = 2'b00;
    localparam logic [1:0] COND_Z      = 2'b01;
    localparam logic [1:0] COND_C      = 2'b10;
    localparam logic [1:0] COND_NEVER  = 2'b11;

    localparam logic ALU_OP_ADD  = 1'b0;
    localparam logic ALU_OP_NAND = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_EVAL  = 2'b01,
        ST_WRITE = 2'b10,
        ST_SKIP  = 2'b11
    } state_t;

    function automatic logic cond_exec(
        input logic [1:0] cond,
        input logic       c_flag,
        input logic       z_flag
    );
        logic ex;
        ex = 1'b0;
        unique case (cond)
            COND_ALWAYS: ex = 1'b1;
            COND_Z:      ex = z_flag;
            COND_C:      ex = c_flag;
            COND_NEVER:  ex = 1'b0;
            default:     ex = 1'b0;
        endcase
        return ex;
    endfunction

endpackage

// File: rtl/alu_writeback_ctrl_flag_cond_eval.sv
// Conditional-execution decision from the condition field and the
// architectural flags. Ports: cond, carry_flag, zero_flag -> exec.
module alu_writeback_ctrl_flag_cond_eval
    import alu_writeback_ctrl_pkg::*;
(
    input  logic [1:0] cond,
    input  logic       carry_flag,
    input  logic       zero_flag,
    output logic       exec
);

    always_comb begin
        exec = cond_exec(cond, carry_flag, zero_flag);
    end

endmodule

// File: rtl/alu_writeback_ctrl.sv
// ALU writeback controller: captures one ALU result, resolves its condition
// against the owned C/Z flags, then writes the register file and updates flags.
// Ports: clk, reset (sync, active-high); in_valid/in_ready handshake with ALU
// fields alu_out/alu_carry/alu_zero/alu_op/cond/dest; register-file write
// rf_we/rf_waddr/rf_wdata; carry_flag/zero_flag; done/skipped/pc_written pulses.
module alu_writeback_ctrl
    import alu_writeback_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW,
    parameter int PC_REG = DEF_PC_REG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry,
    input  logic              alu_zero,
    input  logic              alu_op,
    input  logic [1:0]        cond,
    input  logic [REG_AW-1:0] dest,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              carry_flag,
    output logic              zero_flag,
    output logic              done,
    output logic              skipped,
    output logic              pc_written
);

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] out_q;
    logic              carry_q;
    logic              zero_q;
    logic              op_q;
    logic [1:0]        cond_q;
    logic [REG_AW-1:0] dest_q;

    logic              exec;
    logic              cap_en;
    logic              wr_en;
    logic              skip_en;

    alu_writeback_ctrl_flag_cond_eval u_cond (
        .cond       (cond_q),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .exec       (exec)
    );

    assign in_ready = (state_q == ST_IDLE);

    // Outputs are registered on the edge leaving EVAL, so the
    // write pulse and new flags are both visible during WRITE.
    always_comb begin
        state_d = state_q;
        cap_en  = 1'b0;
        wr_en   = 1'b0;
        skip_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    cap_en  = 1'b1;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                wr_en   = exec;
                skip_en = ~exec;
                state_d = exec ? ST_WRITE : ST_SKIP;
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_SKIP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            out_q      <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            op_q       <= ALU_OP_ADD;
            cond_q     <= COND_ALWAYS;
            dest_q     <= '0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            carry_flag <= 1'b0;
            zero_flag  <= 1'b0;
            done       <= 1'b0;
            skipped    <= 1'b0;
            pc_written <= 1'b0;
        end else begin
            state_q    <= state_d;
            rf_we      <= wr_en;
            done       <= wr_en | skip_en;
            skipped    <= skip_en;
            pc_written <= wr_en && (dest_q == REG_AW'(PC_REG));
            if (cap_en) begin
                out_q   <= alu_out;
                carry_q <= alu_carry;
                zero_q  <= alu_zero;
                op_q    <= alu_op;
                cond_q  <= cond;
                dest_q  <= dest;
            end
            if (wr_en) begin
                rf_waddr  <= dest_q;
                rf_wdata  <= out_q;
                zero_flag <= zero_q;
                // NAND-type results leave the carry flag untouched
                if (op_q == ALU_OP_ADD) begin
                    carry_flag <= carry_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_writeback_ctrl.sv
// Self-checking bench for alu_writeback_ctrl: directed and randomized
// transactions against a transaction-level flag/writeback model.
module tb_alu_writeback_ctrl;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] alu_out;
    logic        alu_carry;
    logic        alu_zero;
    logic        alu_op;
    logic [1:0]  cond;
    logic [2:0]  dest;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        carry_flag;
    logic        zero_flag;
    logic        done;
    logic        skipped;
    logic        pc_written;

    int tests;
    int fails;
    int cyc;
    int last_acc;
    bit prev_hold;

    // transaction-level model state
    bit          m_c;
    bit          m_z;
    logic [2:0]  m_waddr;
    logic [15:0] m_wdata;

    alu_writeback_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_out    (alu_out),
        .alu_carry  (alu_carry),
        .alu_zero   (alu_zero),
        .alu_op     (alu_op),
        .cond       (cond),
        .dest       (dest),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .done       (done),
        .skipped    (skipped),
        .pc_written (pc_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests = tests + 1;
        if (obs !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, obs, exp, cyc);
        end
    endtask

    task automatic idle_outs(input string tag);
        chk({tag, "_we"}, rf_we, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_skip"}, skipped, 0);
        chk({tag, "_pc"}, pc_written, 0);
    endtask

    // Called just after a negedge. hold=1 keeps in_valid high with junk
    // data after acceptance, as a producer with the next op waiting.
    task automatic run_txn(input logic [15:0] o, input logic c,
                           input logic z, input logic op,
                           input logic [1:0] cd, input logic [2:0] d,
                           input bit hold);
        int w;
        bit ex;
        alu_out   = o;
        alu_carry = c;
        alu_zero  = z;
        alu_op    = op;
        cond      = cd;
        dest      = d;
        in_valid  = 1'b1;
        w = 0;
        while (!in_ready && w < 8) begin
            @(negedge clk);
            w++;
        end
        chk("accept_rdy", in_ready, 1);
        if (prev_hold) chk("accept_gap", cyc - last_acc, 3);
        last_acc = cyc;
        @(posedge clk);
        #1;
        if (hold) begin
            alu_out   = 16'($urandom);
            alu_carry = 1'($urandom);
            alu_zero  = 1'($urandom);
            alu_op    = 1'($urandom);
            cond      = 2'($urandom);
            dest      = 3'($urandom);
        end else begin
            in_valid = 1'b0;
        end
        prev_hold = hold;
        @(negedge clk);
        chk("eval_rdy", in_ready, 0);
        idle_outs("eval");
        ex = (cd == 2'd0) || (cd == 2'd1 && m_z) || (cd == 2'd2 && m_c);
        if (ex) begin
            m_z = z;
            if (op == 1'b0) m_c = c;
            m_waddr = d;
            m_wdata = o;
        end
        @(negedge clk);
        chk("wb_rdy", in_ready, 0);
        chk("wb_we", rf_we, ex);
        chk("wb_done", done, 1);
        chk("wb_skip", skipped, !ex);
        chk("wb_pc", pc_written, ex && d == 3'd7);
        chk("wb_waddr", rf_waddr, m_waddr);
        chk("wb_wdata", rf_wdata, m_wdata);
        chk("wb_cflag", carry_flag, m_c);
        chk("wb_zflag", zero_flag, m_z);
        @(negedge clk);
        chk("post_rdy", in_ready, 1);
        idle_outs("post");
        chk("post_waddr", rf_waddr, m_waddr);
        chk("post_wdata", rf_wdata, m_wdata);
        chk("post_cflag", carry_flag, m_c);
        chk("post_zflag", zero_flag, m_z);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        cyc = 0;
        last_acc = 0;
        prev_hold = 0;
        m_c = 0;
        m_z = 0;
        m_waddr = '0;
        m_wdata = '0;
        reset = 1'b1;
        in_valid = 1'b0;
        alu_out = '0;
        alu_carry = 0;
        alu_zero = 0;
        alu_op = 0;
        cond = '0;
        dest = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_rdy", in_ready, 1);
        idle_outs("rst");
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_cflag", carry_flag, 0);
        chk("rst_zflag", zero_flag, 0);

        // ADD always, then ADZ with Z clear, NAND setting Z, ADZ with Z set
        run_txn(16'h1234, 1, 0, 0, 2'd0, 3'd3, 0);
        run_txn(16'h5555, 0, 0, 0, 2'd1, 3'd2, 0);
        run_txn(16'h0000, 0, 1, 1, 2'd0, 3'd4, 0);
        run_txn(16'habcd, 0, 0, 0, 2'd1, 3'd1, 0);
        // never, then PC write, then ADC with C clear and set
        run_txn(16'hffff, 1, 1, 0, 2'd3, 3'd5, 0);
        run_txn(16'h0100, 1, 0, 0, 2'd0, 3'd7, 0);
        run_txn(16'h0042, 0, 0, 0, 2'd2, 3'd6, 0);
        run_txn(16'h0043, 0, 1, 1, 2'd2, 3'd0, 0);

        // reset while a write is pending in EVAL
        alu_out = 16'h7777;
        alu_carry = 1;
        alu_zero = 1;
        alu_op = 0;
        cond = 2'd0;
        dest = 3'd2;
        in_valid = 1'b1;
        chk("rsteval_acc", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        m_c = 0;
        m_z = 0;
        m_waddr = '0;
        m_wdata = '0;
        #1 reset = 1'b0;
        chk("rsteval_rdy", in_ready, 1);
        chk("rsteval_cflag", carry_flag, 0);
        chk("rsteval_zflag", zero_flag, 0);
        idle_outs("rsteval");
        repeat (2) begin
            @(negedge clk);
            idle_outs("rsteval_after");
            chk("rsteval_wdata", rf_wdata, 0);
        end
        prev_hold = 0;

        // back-to-back with in_valid held
        run_txn(16'h1111, 1, 0, 0, 2'd0, 3'd1, 1);
        run_txn(16'h2222, 0, 0, 0, 2'd2, 3'd2, 1);
        run_txn(16'h3333, 0, 1, 1, 2'd0, 3'd7, 0);

        // randomized
        for (int i = 0; i < 60; i++) begin
            run_txn(16'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), 2'($urandom), 3'($urandom),
                    bit'($urandom_range(0, 1)));
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
